// File: rtl/micro_seq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing opcodes,
// run state, and the microword layout {ctrl, seq_op, cond_sel, cond_pol, target}.
package micro_seq_pkg;

  localparam int SEQ_OP_W = 3;

  localparam logic [SEQ_OP_W-1:0] SEQ_NEXT     = 3'd0;
  localparam logic [SEQ_OP_W-1:0] SEQ_JUMP     = 3'd1;
  localparam logic [SEQ_OP_W-1:0] SEQ_CJMP     = 3'd2;
  localparam logic [SEQ_OP_W-1:0] SEQ_CALL     = 3'd3;
  localparam logic [SEQ_OP_W-1:0] SEQ_RET      = 3'd4;
  localparam logic [SEQ_OP_W-1:0] SEQ_DISPATCH = 3'd5;
  localparam logic [SEQ_OP_W-1:0] SEQ_HALT     = 3'd6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Width of the sequencing part of the microword (everything below ctrl).
  function automatic int seq_w(input int csel_w, input int upc_w);
    return SEQ_OP_W + csel_w + 1 + upc_w;
  endfunction

  // Field LSB offsets; target sits at bit 0.
  function automatic int pol_lsb(input int upc_w);
    return upc_w;
  endfunction

  function automatic int csel_lsb(input int upc_w);
    return upc_w + 1;
  endfunction

  function automatic int op_lsb(input int csel_w, input int upc_w);
    return upc_w + 1 + csel_w;
  endfunction

  function automatic int ctrl_lsb(input int csel_w, input int upc_w);
    return seq_w(csel_w, upc_w);
  endfunction

endpackage

// File: rtl/micro_return_stack.sv
// LIFO of micro-PC return addresses for CALL/RET. Pushes while full and pops
// while empty are ignored so the pointer can never leave 0..STACK_DEPTH.
module micro_return_stack #(
  parameter int UPC_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [UPC_W-1:0] data_i,
  output logic [UPC_W-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [UPC_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  sp_dec;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign sp_dec  = sp_q - SP_W'(1);
  assign wr_idx  = sp_q[IDX_W-1:0];
  assign rd_idx  = sp_dec[IDX_W-1:0];
  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = empty_o ? '0 : mem_q[rd_idx];

  // NOTE: every entry is reset, so a stale slot can never leak X into the
  // micro-PC; the array is tiny, so this costs almost nothing.
  // NOTE: sequential state is written only with non-blocking assignments so
  // all registers update together at the edge regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
      sp_q          <= sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_dec;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: forms the ROM address {opcode_q, upc_q}, forwards the
// ctrl field to the datapath and picks the next micro-PC from the seq field.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int  OPCODE_W    = 8,
  parameter int  UPC_W       = 8,
  parameter int  CTRL_W      = 32,
  parameter int  FLAG_W      = 4,
  parameter int  STACK_DEPTH = 4,
  localparam int CSEL_W      = $clog2(FLAG_W),
  localparam int SEQ_W       = seq_w(CSEL_W, UPC_W)
) (
  input  logic                      useq_clk,
  input  logic                      useq_rst,
  input  logic                      useq_stall_in,
  input  logic [OPCODE_W-1:0]       useq_opcode_in,
  input  logic [FLAG_W-1:0]         useq_flags_in,
  output logic [OPCODE_W+UPC_W-1:0] useq_rom_addr_out,
  input  logic [CTRL_W+SEQ_W-1:0]   useq_rom_data_in,
  output logic [CTRL_W-1:0]         useq_ctrl_out,
  output logic                      useq_halt_out,
  output logic                      useq_stack_err_out
);

  localparam int POL_POS  = pol_lsb(UPC_W);
  localparam int CSEL_LSB = csel_lsb(UPC_W);
  localparam int OP_LSB   = op_lsb(CSEL_W, UPC_W);
  localparam int CTRL_LSB = ctrl_lsb(CSEL_W, UPC_W);

  // Microword fields
  logic [CTRL_W-1:0]   ctrl_f;
  logic [SEQ_OP_W-1:0] op_f;
  logic [CSEL_W-1:0]   csel_f;
  logic                pol_f;
  logic [UPC_W-1:0]    tgt_f;

  assign ctrl_f = useq_rom_data_in[CTRL_LSB +: CTRL_W];
  assign op_f   = useq_rom_data_in[OP_LSB +: SEQ_OP_W];
  assign csel_f = useq_rom_data_in[CSEL_LSB +: CSEL_W];
  assign pol_f  = useq_rom_data_in[POL_POS];
  assign tgt_f  = useq_rom_data_in[0 +: UPC_W];

  // Registers
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [UPC_W-1:0]    upc_q, upc_d;
  run_state_e          state_q, state_d;
  logic                stack_err_q, stack_err_d;

  logic [UPC_W-1:0] upc_inc;
  logic             cond;
  logic             stk_push;
  logic             stk_pop;
  logic [UPC_W-1:0] stk_top;
  logic             stk_full;
  logic             stk_empty;

  assign upc_inc = upc_q + UPC_W'(1);

  // A selector beyond the implemented flags leaves only the polarity bit.
  generate
    if (FLAG_W == (1 << CSEL_W)) begin : g_cond_full
      assign cond = useq_flags_in[csel_f] ^ pol_f;
    end else begin : g_cond_part
      always_comb begin
        cond = pol_f;
        if (int'(csel_f) < FLAG_W) begin
          cond = useq_flags_in[csel_f] ^ pol_f;
        end
      end
    end
  endgenerate

  micro_return_stack #(
    .UPC_W      (UPC_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk_i  (useq_clk),
    .rst_i  (useq_rst),
    .push_i (stk_push),
    .pop_i  (stk_pop),
    .data_i (upc_inc),
    .top_o  (stk_top),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    opcode_d    = opcode_q;
    upc_d       = upc_q;
    state_d     = state_q;
    stack_err_d = stack_err_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;

    if (state_q == ST_RUN && !useq_stall_in) begin
      case (op_f)
        SEQ_JUMP: upc_d = tgt_f;
        SEQ_CJMP: upc_d = cond ? tgt_f : upc_inc;
        SEQ_CALL: begin
          if (stk_full) begin
            state_d     = ST_HALT;
            stack_err_d = 1'b1;
          end else begin
            stk_push = 1'b1;
            upc_d    = tgt_f;
          end
        end
        SEQ_RET: begin
          if (stk_empty) begin
            state_d     = ST_HALT;
            stack_err_d = 1'b1;
          end else begin
            stk_pop = 1'b1;
            upc_d   = stk_top;
          end
        end
        SEQ_DISPATCH: begin
          opcode_d = useq_opcode_in;
          upc_d    = '0;
        end
        SEQ_HALT: state_d = ST_HALT;
        default:  upc_d = upc_inc;  // NEXT and the reserved encoding
      endcase
    end
  end

  always_ff @(posedge useq_clk or posedge useq_rst) begin
    if (useq_rst) begin
      opcode_q    <= '0;
      upc_q       <= '0;
      state_q     <= ST_RUN;
      stack_err_q <= 1'b0;
    end else begin
      opcode_q    <= opcode_d;
      upc_q       <= upc_d;
      state_q     <= state_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign useq_rom_addr_out  = {opcode_q, upc_q};
  assign useq_halt_out      = (state_q == ST_HALT);
  assign useq_stack_err_out = stack_err_q;
  assign useq_ctrl_out      = (useq_rst || useq_halt_out || useq_stall_in) ? '0 : ctrl_f;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a randomized
// run against a queue-based behavioural model of the sequencing rules.
module tb_micro_sequencer;

  localparam int STACK_DEPTH = 4;

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_CJMP = 3'd2, OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4, OP_DISP = 3'd5, OP_HALT = 3'd6, OP_RSVD = 3'd7;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [2:0]  op;
    logic [1:0]  csel;
    logic        pol;
    logic [7:0]  tgt;
  } mword_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [7:0]  opcode;
  logic [3:0]  flags;
  logic [15:0] addr;
  logic [45:0] rdata;
  logic [31:0] ctrl;
  logic        halt;
  logic        err;

  mword_t rom [65536];
  assign rdata = rom[addr];

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_opcode;
  int m_upc;
  int m_stack[$];
  bit m_halt;
  bit m_err;

  micro_sequencer dut (
    .useq_clk          (clk),
    .useq_rst          (rst),
    .useq_stall_in     (stall),
    .useq_opcode_in    (opcode),
    .useq_flags_in     (flags),
    .useq_rom_addr_out (addr),
    .useq_rom_data_in  (rdata),
    .useq_ctrl_out     (ctrl),
    .useq_halt_out     (halt),
    .useq_stack_err_out(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic init_rom();
    for (int a = 0; a < 65536; a++) begin
      rom[a] = '{ctrl: 32'hC0DE_0000 | a, op: OP_NEXT, csel: 2'd0, pol: 1'b0, tgt: 8'd0};
    end
  endtask

  task automatic put(input int a, input logic [2:0] op, input int tgt, input logic [1:0] csel,
                     input logic pol);
    rom[a].op   = op;
    rom[a].tgt  = 8'(tgt);
    rom[a].csel = csel;
    rom[a].pol  = pol;
  endtask

  task automatic m_reset();
    m_opcode = 0;
    m_upc    = 0;
    m_stack.delete();
    m_halt   = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock of the sequencing rules, applied to the model.
  task automatic model_step();
    mword_t w;
    if (rst || m_halt || stall) return;
    w = rom[m_opcode * 256 + m_upc];
    case (w.op)
      OP_JUMP: m_upc = int'(w.tgt);
      OP_CJMP: m_upc = (flags[w.csel] ^ w.pol) ? int'(w.tgt) : (m_upc + 1) % 256;
      OP_CALL: begin
        if (m_stack.size() == STACK_DEPTH) begin
          m_halt = 1'b1;
          m_err  = 1'b1;
        end else begin
          m_stack.push_back((m_upc + 1) % 256);
          m_upc = int'(w.tgt);
        end
      end
      OP_RET: begin
        if (m_stack.size() == 0) begin
          m_halt = 1'b1;
          m_err  = 1'b1;
        end else begin
          m_upc = m_stack.pop_back();
        end
      end
      OP_DISP: begin
        m_opcode = int'(opcode);
        m_upc    = 0;
      end
      OP_HALT: m_halt = 1'b1;
      default: m_upc = (m_upc + 1) % 256;
    endcase
  endtask

  // Advance one cycle; returns 1 ns after the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    stall  = 1'b0;
    flags  = 4'd0;
    opcode = 8'd0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    init_rom();
    rst = 1'b1; stall = 1'b0; flags = 4'd0; opcode = 8'h77;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (addr !== 16'h0000) begin bad++; $display("FAIL rst_addr: got %h want 0000", addr); end
    total++; if (ctrl !== 32'h0)    begin bad++; $display("FAIL rst_ctrl: got %h want 0", ctrl); end
    total++; if (halt !== 1'b0)     begin bad++; $display("FAIL rst_halt: got %b want 0", halt); end
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (addr !== 16'(i)) begin bad++; $display("FAIL step_addr[%0d]: got %h want %h", i, addr, 16'(i)); end
      total++;
      if (ctrl !== (32'hC0DE_0000 | i)) begin
        bad++; $display("FAIL step_ctrl[%0d]: got %h want %h", i, ctrl, 32'hC0DE_0000 | i);
      end
      tick();
    end
  endtask

  task automatic test_dispatch_wrap();
    logic [15:0] exp_seq [7];
    exp_seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h2A00, 16'h2AFF, 16'h2A00};
    init_rom();
    put(16'h0003, OP_DISP, 0, 2'd0, 1'b0);
    put(16'h2A00, OP_JUMP, 8'hFF, 2'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      opcode = (i == 3) ? 8'h2A : 8'h55;
      #1;
      total++;
      if (addr !== exp_seq[i]) begin bad++; $display("FAIL dispatch_addr[%0d]: got %h want %h", i, addr, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_cjmp();
    logic [3:0]  t_flags [5];
    logic        t_pol   [5];
    logic [15:0] t_exp   [5];
    t_flags = '{4'b0010, 4'b0000, 4'b0010, 4'b1101, 4'b1101};
    t_pol   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t_exp   = '{16'h0040, 16'h0011, 16'h0011, 16'h0040, 16'h0011};
    init_rom();
    put(16'h0000, OP_JUMP, 8'h10, 2'd0, 1'b0);
    put(16'h0040, OP_JUMP, 8'h10, 2'd0, 1'b0);
    put(16'h0011, OP_JUMP, 8'h10, 2'd0, 1'b0);
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      put(16'h0010, OP_CJMP, 8'h40, 2'd1, t_pol[i]);
      flags = t_flags[i];
      #1;
      total++;
      if (addr !== 16'h0010) begin bad++; $display("FAIL cjmp_at[%0d]: got %h want 0010", i, addr); end
      tick();
      total++;
      if (addr !== t_exp[i]) begin bad++; $display("FAIL cjmp_next[%0d]: got %h want %h", i, addr, t_exp[i]); end
      tick();
    end
  endtask

  task automatic test_call_ret();
    logic [15:0] exp_seq [7];
    exp_seq = '{16'h0000, 16'h0005, 16'h0020, 16'h0021, 16'h0030, 16'h0022, 16'h0006};
    init_rom();
    put(16'h0000, OP_JUMP, 8'h05, 2'd0, 1'b0);
    put(16'h0005, OP_CALL, 8'h20, 2'd0, 1'b0);
    put(16'h0021, OP_CALL, 8'h30, 2'd0, 1'b0);
    put(16'h0030, OP_RET,  0,     2'd0, 1'b0);
    put(16'h0022, OP_RET,  0,     2'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (addr !== exp_seq[i]) begin bad++; $display("FAIL callret_addr[%0d]: got %h want %h", i, addr, exp_seq[i]); end
      if (i < 6) tick();
    end
    total++; if (err !== 1'b0)  begin bad++; $display("FAIL callret_err: got %b want 0", err); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL callret_halt: got %b want 0", halt); end
  endtask

  task automatic test_stack_errors();
    // Overflow: CALL to itself at 0x08 fills the stack, the fifth one faults.
    init_rom();
    put(16'h0000, OP_JUMP, 8'h08, 2'd0, 1'b0);
    put(16'h0008, OP_CALL, 8'h08, 2'd0, 1'b0);
    do_reset();
    tick();
    for (int i = 0; i < STACK_DEPTH; i++) begin
      tick();
      total++;
      if (addr !== 16'h0008 || halt !== 1'b0) begin
        bad++; $display("FAIL ovf_fill[%0d]: got addr=%h halt=%b want addr=0008 halt=0", i, addr, halt);
      end
    end
    tick();
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL ovf_halt: got %b want 1", halt); end
    total++; if (err !== 1'b1)  begin bad++; $display("FAIL ovf_err: got %b want 1", err); end
    for (int i = 0; i < 3; i++) begin
      flags = 4'($urandom); stall = 1'(i == 1);
      #1;
      total++;
      if (addr !== 16'h0008 || ctrl !== 32'h0) begin
        bad++; $display("FAIL ovf_frozen[%0d]: got addr=%h ctrl=%h want addr=0008 ctrl=0", i, addr, ctrl);
      end
      tick();
    end
    stall = 1'b0;
    // Asynchronous reset in the middle of a cycle.
    rst = 1'b1;
    #1;
    total++;
    if (halt !== 1'b0 || err !== 1'b0 || addr !== 16'h0000) begin
      bad++; $display("FAIL ovf_rst: got halt=%b err=%b addr=%h want 0 0 0000", halt, err, addr);
    end
    // Underflow: RET with an empty stack right after reset.
    put(16'h0000, OP_RET, 0, 2'd0, 1'b0);
    do_reset();
    tick();
    total++;
    if (halt !== 1'b1 || err !== 1'b1 || addr !== 16'h0000 || ctrl !== 32'h0) begin
      bad++; $display("FAIL udf: got halt=%b err=%b addr=%h ctrl=%h want 1 1 0000 0", halt, err, addr, ctrl);
    end
  endtask

  task automatic test_stall_halt();
    init_rom();
    put(16'h0000, OP_JUMP, 8'h12, 2'd0, 1'b0);
    put(16'h0013, OP_HALT, 0, 2'd0, 1'b0);
    do_reset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (addr !== 16'h0012 || ctrl !== 32'h0) begin
        bad++; $display("FAIL stall[%0d]: got addr=%h ctrl=%h want addr=0012 ctrl=0", i, addr, ctrl);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    total++;
    if (addr !== 16'h0012 || ctrl !== 32'hC0DE_0012) begin
      bad++; $display("FAIL unstall: got addr=%h ctrl=%h want addr=0012 ctrl=c0de0012", addr, ctrl);
    end
    tick();
    total++;
    if (addr !== 16'h0013 || halt !== 1'b0) begin
      bad++; $display("FAIL pre_halt: got addr=%h halt=%b want addr=0013 halt=0", addr, halt);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      flags = 4'($urandom); opcode = 8'($urandom);
      #1;
      total++;
      if (addr !== 16'h0013 || halt !== 1'b1 || err !== 1'b0 || ctrl !== 32'h0) begin
        bad++; $display("FAIL halted[%0d]: got addr=%h halt=%b err=%b ctrl=%h want 0013 1 0 0", i, addr, halt, err, ctrl);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int halted_for;
    int shown;
    logic [15:0] e_addr;
    logic [31:0] e_ctrl;
    init_rom();
    for (int a = 0; a < 1024; a++) begin
      rom[a].ctrl = $urandom;
      rom[a].op   = ($urandom_range(0, 99) < 2) ? OP_HALT : 3'($urandom_range(0, 7));
      if (rom[a].op == OP_HALT && $urandom_range(0, 1) == 1) rom[a].op = OP_RSVD;
      rom[a].csel = 2'($urandom);
      rom[a].pol  = 1'($urandom);
      rom[a].tgt  = 8'($urandom);
    end
    do_reset();
    halted_for = 0;
    shown      = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ((m_halt && halted_for > 3) || $urandom_range(0, 299) == 0) begin
        do_reset();
        halted_for = 0;
      end
      stall  = ($urandom_range(0, 3) == 0);
      flags  = 4'($urandom);
      opcode = 8'($urandom_range(0, 3));
      #1;
      e_addr = 16'(m_opcode * 256 + m_upc);
      e_ctrl = (m_halt || stall) ? 32'h0 : rom[e_addr].ctrl;
      total += 4;
      if (addr !== e_addr || ctrl !== e_ctrl || halt !== m_halt || err !== m_err) begin
        if (addr !== e_addr) bad++;
        if (ctrl !== e_ctrl) bad++;
        if (halt !== m_halt) bad++;
        if (err !== m_err)   bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random[%0d]: got addr=%h ctrl=%h halt=%b err=%b want addr=%h ctrl=%h halt=%b err=%b",
                   cyc, addr, ctrl, halt, err, e_addr, e_ctrl, m_halt, m_err);
        end
      end
      if (m_halt) halted_for++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flags = 4'd0; opcode = 8'd0;
    test_reset();
    test_dispatch_wrap();
    test_cjmp();
    test_call_ret();
    test_stack_errors();
    test_stall_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Parametrised microprogram sequencer, the next-generation replacement for the fixed instruction-counter and instruction-memory control path. It forms the microcode ROM address from a latched opcode and a micro-PC. The ROM is external and combinational. The sequencer drives the control field of the fetched word to the datapath, and a sequencing field in the same word selects the next micro-PC. Additions over the current control path: conditional branches on ALU flags, micro-subroutine call/return, opcode dispatch, halt, stall, and stack-error detection.

Parameters:
OPCODE_W, 8, opcode width; forms the upper ROM address bits.
UPC_W, 8, micro-PC width; forms the lower ROM address bits and the branch target width.
CTRL_W, 32, control field width driven to the datapath.
FLAG_W, 4, number of condition flags; CSEL_W = clog2(FLAG_W).
STACK_DEPTH, 4, return-stack entries, must be 2 or more.

Ports:
useq_clk  in  1  clock, rising edge.
useq_rst  in  1  asynchronous, active-high reset.
useq_stall_in  in  1  freeze sequencing for this cycle.
useq_opcode_in  in  OPCODE_W  opcode from the instruction register, sampled only on DISPATCH.
useq_flags_in  in  FLAG_W  ALU status flags.
useq_rom_addr_out  out  OPCODE_W+UPC_W  microcode address {opcode_q, upc_q}.
useq_rom_data_in  in  CTRL_W+SEQ_W  microword = {ctrl[CTRL_W], seq_op[3], cond_sel[CSEL_W], cond_pol[1], target[UPC_W]}, with the ctrl field as the MSBs.
useq_ctrl_out  out  CTRL_W  control word to the datapath.
useq_halt_out  out  1  sequencer halted (sticky).
useq_stack_err_out  out  1  stack overflow or underflow occurred (sticky).

Behaviour:
- Reset (asynchronous, active-high): opcode_q=0, upc_q=0, sp=0, halt=0, stack_err=0, all stack entries 0.
- While in reset: useq_rom_addr_out=0 and useq_ctrl_out=0. The first address after reset release is 0, which is the fetch routine at opcode row 0.
- useq_rom_addr_out is a combinational function of registers only.
- useq_ctrl_out is the ctrl field, combinational from useq_rom_data_in.
- useq_ctrl_out is forced to 0 when halt=1, when useq_stall_in=1, or when useq_rst=1.
- cond = useq_flags_in[cond_sel] XOR cond_pol. If cond_sel >= FLAG_W, cond = cond_pol.
- seq_op encodings, with the next-state update on the clock edge:
  - 0 NEXT: upc <= upc+1, wrapping modulo 2^UPC_W (255 -> 0 at default).
  - 1 JUMP: upc <= target.
  - 2 CJMP: upc <= cond ? target : upc+1.
  - 3 CALL: push upc+1 and set sp <= sp+1, then upc <= target.
  - 4 RET: sp <= sp-1, then upc <= stack[sp-1].
  - 5 DISPATCH: opcode_q <= useq_opcode_in, upc <= 0.
  - 6 HALT: halt <= 1, upc held.
  - 7: reserved, behaves as NEXT.
- Priority: reset > halt > stall > seq_op.
  - While halted, all registers hold. Only reset clears halt.
  - When stalled, all registers hold and the same microword is re-presented on the next unstalled cycle.
- CALL with sp==STACK_DEPTH (overflow):
  - No push and no upc change.
  - stack_err <= 1 and halt <= 1 on the same edge.
- RET with sp==0 (underflow): same response as overflow: no pop, no upc change, stack_err <= 1 and halt <= 1.
- A CALL target of upc itself is legal.
- DISPATCH does not clear the stack.
- Combinational loop rule: useq_rom_data_in must depend only on useq_rom_addr_out, giving one microword per cycle.
- Latency: the datapath sees the control word in the same cycle the address is presented. A branch takes effect on the next cycle; there are no delay slots.

Decomposition:
- Shared package micro_seq_pkg holds:
  - the seq_op localparams: SEQ_NEXT=0, SEQ_JUMP=1, SEQ_CJMP=2, SEQ_CALL=3, SEQ_RET=4, SEQ_DISPATCH=5, SEQ_HALT=6;
  - the SEQ_W expression, 3+CSEL_W+1+UPC_W;
  - the microword field offsets.
- One sub-module, micro_return_stack (parameters UPC_W and STACK_DEPTH):
  - inputs push, pop and data;
  - outputs top, full and empty;
  - asynchronous active-high reset.
  - The sequencer gates push/pop on full/empty and on stall/halt.

Test Plan:
1. Reset and linear stepping: release reset with ROM row 0 containing NEXT words -> rom_addr 0x0000, 0x0001, 0x0002 on successive cycles; ctrl_out is 0 during reset.
2. Dispatch and wrap: DISPATCH at 0x0003 with opcode_in=0x2A -> next address 0x2A00. NEXT at 0x2AFF -> next address 0x2A00.
3. Conditional branch, using the same microword CJMP cond_sel=1 pol=0 target=0x40 at 0x0010:
   - flags=4'b0010 -> next address 0x0040.
   - flags=4'b0000 -> next address 0x0011.
   - pol=1 with flags=4'b0010 -> next address 0x0011.
4. Call/return nesting: CALL 0x20 at 0x05, CALL 0x30 at 0x21, RET at 0x30, RET at 0x22 -> address sequence 05, 20, 21, 30, 22, 06; stack_err stays 0.
5. Stack errors:
   - Overflow: with STACK_DEPTH=4, a fifth nested CALL -> stack_err=1, halt=1, address frozen, ctrl_out=0.
   - Underflow: after reset, a RET -> stack_err=1, halt=1.
   - Asserting reset mid-halt clears both flags and returns the address to 0x0000.
6. Stall and halt:
   - Stall held for 3 cycles at 0x0012 -> address held, ctrl_out=0; on release, the microword at 0x0012 executes once.
   - HALT at 0x0013 -> halt=1, address held at 0x0013 indefinitely.
